motor_cmd_driver: RTL

MOTOR_CMD_DRIVER -- requirements
Module: motor_cmd_driver

---
 rtl/drive_pkg.sv | 86 ++++++++
 rtl/wheel_channel.sv | 96 +++++++++
 rtl/motor_cmd_driver.sv | 82 ++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared drive definitions: mode codes, H-bridge direction encodings and the
// mode -> per-wheel {dir, duty} target table used by the drive FSM and motor driver.
package drive_pkg;

    typedef enum logic [4:0] {
        MODE_IDLE         = 5'd0,
        MODE_START        = 5'd1,
        MODE_COUNT        = 5'd2,
        MODE_STRAIGHT     = 5'd3,
        MODE_CHOOSE       = 5'd4,
        MODE_LEFT         = 5'd5,
        MODE_RIGHT        = 5'd6,
        MODE_BACK         = 5'd7,
        MODE_LITTLE_LEFT  = 5'd8,
        MODE_LITTLE_RIGHT = 5'd9,
        MODE_STOP         = 5'd30,
        MODE_ERROR        = 5'd31
    } mode_e;

    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_REV   = 2'b01,
        DIR_FWD   = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        WS_RUN,
        WS_RAMP_DOWN,
        WS_DEAD
    } wheel_state_e;

    typedef struct packed {
        dir_e       dir;
        logic [7:0] duty;
    } wheel_target_t;

    typedef struct packed {
        logic          stop;
        wheel_target_t left;
        wheel_target_t right;
    } drive_target_t;

    function automatic drive_target_t run_target(input dir_e ld, input logic [7:0] lduty,
                                                 input dir_e rd, input logic [7:0] rduty);
        drive_target_t t;
        t.stop       = 1'b0;
        t.left.dir   = ld;
        t.left.duty  = lduty;
        t.right.dir  = rd;
        t.right.duty = rduty;
        return t;
    endfunction

    // Anything not explicitly listed is stop-class: coast both wheels at zero duty.
    function automatic drive_target_t mode_target(input logic [4:0] mode);
        drive_target_t t;
        t.stop       = 1'b1;
        t.left.dir   = DIR_COAST;
        t.left.duty  = 8'd0;
        t.right.dir  = DIR_COAST;
        t.right.duty = 8'd0;
        case (mode)
            MODE_STRAIGHT:     t = run_target(DIR_FWD, 8'd200, DIR_FWD, 8'd200);
            MODE_CHOOSE:       t = run_target(DIR_FWD, 8'd120, DIR_FWD, 8'd120);
            MODE_LEFT:         t = run_target(DIR_REV, 8'd160, DIR_FWD, 8'd160);
            MODE_RIGHT:        t = run_target(DIR_FWD, 8'd160, DIR_REV, 8'd160);
            MODE_BACK:         t = run_target(DIR_REV, 8'd150, DIR_REV, 8'd150);
            MODE_LITTLE_LEFT:  t = run_target(DIR_FWD, 8'd120, DIR_FWD, 8'd200);
            MODE_LITTLE_RIGHT: t = run_target(DIR_FWD, 8'd200, DIR_FWD, 8'd120);
            default:           ;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                               input logic [7:0] step);
        logic [7:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return cur + ((diff > step) ? step : diff);
        end
        diff = cur - tgt;
        return cur - ((diff > step) ? step : diff);
    endfunction

endpackage

// File: rtl/wheel_channel.sv
// One wheel: RUN / RAMP_DOWN / DEAD sequencing, duty ramp, dead-time counter and
// the registered PWM compare against the shared pwm counter.
module wheel_channel
    import drive_pkg::*;
#(
    parameter int RAMP_STEP = 8,
    parameter int DEAD_CYC  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop,
    input  logic       ramp_tick,
    input  dir_e       tgt_dir,
    input  logic [7:0] tgt_duty,
    input  logic [7:0] pwm_cnt,
    output dir_e       dir,
    output logic       pwm,
    output logic       at_target_next
);

    localparam int             DW        = $clog2(DEAD_CYC + 1);
    localparam logic [DW-1:0]  DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [7:0]     STEP      = 8'(RAMP_STEP);

    wheel_state_e  state, state_n;
    dir_e          dir_n;
    logic [7:0]    cur_duty, duty_n;
    logic [DW-1:0] dead_cnt, dead_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WS_RUN;
            dir      <= DIR_COAST;
            cur_duty <= 8'd0;
            dead_cnt <= '0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_n;
            dir      <= dir_n;
            cur_duty <= duty_n;
            dead_cnt <= dead_n;
            pwm      <= stop ? 1'b0 : (pwm_cnt < cur_duty);
        end
    end

    // A reversal always ramps to zero, then coasts for the dead time before re-engaging.
    always_comb begin
        state_n = state;
        dir_n   = dir;
        duty_n  = cur_duty;
        dead_n  = dead_cnt;
        if (stop) begin
            state_n = WS_RUN;
            dir_n   = DIR_COAST;
            duty_n  = 8'd0;
            dead_n  = '0;
        end else begin
            case (state)
                WS_RUN: begin
                    if (dir == tgt_dir) begin
                        if (ramp_tick) duty_n = ramp_toward(cur_duty, tgt_duty, STEP);
                    end else if (dir == DIR_COAST) begin
                        dir_n  = tgt_dir;
                        duty_n = 8'd0;
                    end else begin
                        state_n = WS_RAMP_DOWN;
                    end
                end
                WS_RAMP_DOWN: begin
                    if (tgt_dir == dir) begin
                        state_n = WS_RUN;
                    end else if (cur_duty == 8'd0) begin
                        state_n = WS_DEAD;
                        dir_n   = DIR_COAST;
                        dead_n  = '0;
                    end else if (ramp_tick) begin
                        duty_n = ramp_toward(cur_duty, 8'd0, STEP);
                    end
                end
                WS_DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        state_n = WS_RUN;
                        dir_n   = tgt_dir;
                        duty_n  = 8'd0;
                        dead_n  = '0;
                    end else begin
                        dead_n = dead_cnt + DW'(1);
                    end
                end
                default: state_n = WS_RUN;
            endcase
        end
        at_target_next = (state_n == WS_RUN) && (dir_n == tgt_dir) && (duty_n == tgt_duty);
    end

endmodule

// File: rtl/motor_cmd_driver.sv
// Motor command driver: decodes the drive mode into per-wheel targets and hosts the
// shared PWM and ramp dividers feeding two wheel channels.
module motor_cmd_driver
    import drive_pkg::*;
#(
    parameter int PWM_DIV   = 390,
    parameter int RAMP_DIV  = 100000,
    parameter int RAMP_STEP = 8,
    parameter int DEAD_CYC  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] mode,
    output logic [1:0] l_IN,
    output logic [1:0] r_IN,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       settled
);

    localparam int PDW = $clog2(PWM_DIV + 1);
    localparam int RDW = $clog2(RAMP_DIV + 1);

    logic [PDW-1:0] pwm_div_cnt;
    logic [RDW-1:0] ramp_div_cnt;
    logic [7:0]     pwm_cnt;
    logic           ramp_tick;
    drive_target_t  target;
    dir_e           l_dir, r_dir;
    logic           l_at_next, r_at_next;

    assign target    = mode_target(mode);
    assign ramp_tick = (ramp_div_cnt == RDW'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_div_cnt  <= '0;
            pwm_cnt      <= 8'd0;
            ramp_div_cnt <= '0;
            settled      <= 1'b1;
        end else begin
            if (pwm_div_cnt == PDW'(PWM_DIV - 1)) begin
                pwm_div_cnt <= '0;
                pwm_cnt     <= pwm_cnt + 8'd1;
            end else begin
                pwm_div_cnt <= pwm_div_cnt + PDW'(1);
            end
            ramp_div_cnt <= ramp_tick ? '0 : ramp_div_cnt + RDW'(1);
            settled      <= l_at_next & r_at_next;
        end
    end

    wheel_channel #(.RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) u_left (
        .clk            (clk),
        .rst            (rst),
        .stop           (target.stop),
        .ramp_tick      (ramp_tick),
        .tgt_dir        (target.left.dir),
        .tgt_duty       (target.left.duty),
        .pwm_cnt        (pwm_cnt),
        .dir            (l_dir),
        .pwm            (left_pwm),
        .at_target_next (l_at_next)
    );

    wheel_channel #(.RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC)) u_right (
        .clk            (clk),
        .rst            (rst),
        .stop           (target.stop),
        .ramp_tick      (ramp_tick),
        .tgt_dir        (target.right.dir),
        .tgt_duty       (target.right.duty),
        .pwm_cnt        (pwm_cnt),
        .dir            (r_dir),
        .pwm            (right_pwm),
        .at_target_next (r_at_next)
    );

    assign l_IN = l_dir;
    assign r_IN = r_dir;

endmodule
